mel_accumulator: RTL and testbench
==================================

Name: mel_accumulator

Overview:
- Consumer of the mel coefficient ROM. Accepts one 257-bin FFT power frame as a stream.
- Looks up each bin's two sparse (mel_idx, weight) pairs from the coefficient ROM, which has 1-cycle registered read latency.
- Multiply-accumulates the bin power into per-mel-band accumulators.
- Once the frame completes, streams out NUM_MEL band energies, clears the accumulators and accepts the next frame.

Parameters:
- PW_WIDTH, 32, unsigned power sample width.
- W_WIDTH, 16, unsigned weight width, Q0.16.
- IDX_WIDTH, 6, mel index width within a ROM word.
- ACC_WIDTH, 40, accumulator and output width.
- NUM_BINS, 257, FFT bins per frame.
- NUM_MEL, 40, mel bands (must be ≤ 2**IDX_WIDTH).
- ADDR_WIDTH, 9, ROM address width.
- ROM_WIDTH, 44, ROM word width; equals 2*(IDX_WIDTH+W_WIDTH).

Ports:
- clk, in, 1, single clock; all logic rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- s_valid, in, 1, power sample valid.
- s_ready, out, 1, block accepts a sample.
- s_data, in, PW_WIDTH, power of the current bin; bins arrive in order 0..NUM_BINS-1.
- rom_addr, out, ADDR_WIDTH, ROM address.
- rom_data, in, ROM_WIDTH, ROM word {idx1[5:0], w1[15:0], idx2[5:0], w2[15:0]}, valid 1 cycle after rom_addr.
- m_valid, out, 1, mel energy valid.
- m_ready, in, 1, downstream accepts.
- m_data, out, ACC_WIDTH, mel band energy.
- m_idx, out, IDX_WIDTH, band index of m_data.
- m_last, out, 1, high on band NUM_MEL-1.

Behaviour:
- Reset (async assert, sync deassert by usage):
  - state=ACCUM, bin_cnt=0, all accumulators=0, pipeline valids=0.
  - s_ready=0 during reset, then 1 in ACCUM.
  - rom_addr=0, m_valid=0, m_data=0, m_idx=0, m_last=0.
- States:
  - ACCUM: s_ready=1. A sample is accepted when s_valid&s_ready.
  - DRAIN: s_ready=0 for exactly 2 cycles while the pipeline empties.
  - OUTPUT: s_ready=0 while bands are emitted.
- rom_addr is the combinational value of bin_cnt. It is valid in the acceptance cycle, so the ROM samples the correct address at that edge.
- Pipeline:
  - S0, accept: register s_data as p0 and set v0. bin_cnt++. If bin_cnt==NUM_BINS-1 at acceptance, go to DRAIN.
  - S1, when rom_data is valid: compute prod_k = (p0*w_k)>>16 for k=1,2. Products are 48-bit, truncated, then zero-extended to ACC_WIDTH. Register prod_k and idx_k with v1.
  - S2: if v1, acc[idx1]+=prod1 and acc[idx2]+=prod2.
    - If idx1==idx2, the band gets prod1+prod2 in the same cycle.
    - An idx ≥ NUM_MEL, or a weight of 0, contributes nothing.
    - Accumulators are a flop array, so back-to-back writes to the same band have no hazard.
- Accumulation wraps modulo 2**ACC_WIDTH; there is no saturation.
- Gaps in s_valid are allowed. The pipeline advances every cycle and each stage's valid tracks its data.
- DRAIN→OUTPUT occurs after 2 cycles, when the final S2 write has completed.
- OUTPUT:
  - m_valid=1; m_idx=out_cnt; m_data=acc[out_cnt]; m_last=(out_cnt==NUM_MEL-1).
  - On m_valid&m_ready: acc[out_cnt]<=0 and out_cnt++.
  - On the m_last handshake: out_cnt=0, bin_cnt=0, go to ACCUM, and s_ready=1 in the next cycle.
- m_data/m_idx/m_last hold stable while m_valid&!m_ready. Outputs are registered.
- No input is accepted during DRAIN or OUTPUT; the upstream must hold s_valid.
- Reset asserted mid-frame or mid-output: immediately return to reset values. The partial frame is discarded and accumulators are cleared.

Test Plan:
1. Basic frame:
   - ROM word for bin b = {idx1=b%40, w1=0x8000, idx2=63, w2=0}. s_data=1000 for all 257 bins, m_ready=1.
   - Expect bands 0..16 = 7*500 = 3500 and bands 17..39 = 6*500 = 3000.
   - m_last on idx 39. The first m_valid comes exactly 3 cycles after bin 256 is accepted.
2. Dual contribution, same band:
   - Bin 0 = {idx1=5, w1=0xFFFF, idx2=5, w2=0x0001}, s_data=0x10000; all other ROM words have zero weight.
   - Expect acc[5] = 0xFFFF + 0x1 = 0x10000, and every other band 0.
3. Backpressure:
   - Hold m_ready=0 for 10 cycles at idx 3.
   - Expect m_idx=3 and m_data stable throughout, with no skipped or duplicated bands.
4. Bubbly input:
   - Drive s_valid at random 50% duty with the test-1 data.
   - Expect results identical to test 1, and s_ready=0 throughout DRAIN/OUTPUT.
5. Back-to-back frames:
   - Run a second frame with s_data=0.
   - Expect all 40 outputs = 0, proving accumulators are cleared after output.
6. Reset mid-frame:
   - Assert rst_n=0 after bin 100, then run a full test-1 frame.
   - Expect the test-1 values exactly, and m_valid=0 from the reset edge.

Source files
------------

// File: rtl/mel_accumulator_if.sv
// Signal bundle for the mel accumulator: power-sample stream in, coefficient ROM port and band
// energy stream out. The accumulator takes the slave view; its environment takes the master view.
interface mel_accumulator_if #(
    parameter int unsigned PW_WIDTH   = 32,
    parameter int unsigned IDX_WIDTH  = 6,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned ROM_WIDTH  = 44
);
    logic                  s_valid;
    logic                  s_ready;
    logic [PW_WIDTH-1:0]   s_data;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [ROM_WIDTH-1:0]  rom_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [ACC_WIDTH-1:0]  m_data;
    logic [IDX_WIDTH-1:0]  m_idx;
    logic                  m_last;

    modport master (
        output s_valid, s_data, rom_data, m_ready,
        input  s_ready, rom_addr, m_valid, m_data, m_idx, m_last
    );

    modport slave (
        input  s_valid, s_data, rom_data, m_ready,
        output s_ready, rom_addr, m_valid, m_data, m_idx, m_last
    );
endinterface

// File: rtl/mel_accumulator.sv
// Mel filterbank accumulator: weights each FFT bin power by two sparse ROM coefficients, sums
// into per-band accumulators, then streams the band energies out and clears them.
module mel_accumulator #(
    parameter int unsigned PW_WIDTH   = 32,
    parameter int unsigned W_WIDTH    = 16,
    parameter int unsigned IDX_WIDTH  = 6,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned NUM_BINS   = 257,
    parameter int unsigned NUM_MEL    = 40,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned ROM_WIDTH  = 44
) (
    input logic              clk,
    input logic              rst_n,
    mel_accumulator_if.slave bus
);
    localparam int unsigned ProdWidth = PW_WIDTH + W_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastBin  = ADDR_WIDTH'(NUM_BINS - 1);
    localparam logic [IDX_WIDTH-1:0]  LastBand = IDX_WIDTH'(NUM_MEL - 1);

    typedef enum logic [1:0] {StAccum, StDrain, StOutput} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] bin_cnt_q, bin_cnt_d;
    logic [IDX_WIDTH-1:0]  out_cnt_q, out_cnt_d;
    logic                  drain_cnt_q, drain_cnt_d;
    logic                  s_ready_q;
    logic                  accept;
    logic                  out_hs;

    logic [PW_WIDTH-1:0]   p0_q;
    logic                  v0_q;
    logic [IDX_WIDTH-1:0]  idx1_q, idx2_q;
    logic [ACC_WIDTH-1:0]  prod1_q, prod2_q, prod1_d, prod2_d;
    logic                  v1_q;

    logic [ACC_WIDTH-1:0]  acc_q [NUM_MEL];
    logic [ACC_WIDTH-1:0]  acc_d [NUM_MEL];
    logic [ACC_WIDTH-1:0]  m_sel;

    logic                  m_valid_q;
    logic [ACC_WIDTH-1:0]  m_data_q;
    logic [IDX_WIDTH-1:0]  m_idx_q;
    logic                  m_last_q;

    // ROM word layout: {idx1, w1, idx2, w2}
    logic [IDX_WIDTH-1:0] rom_idx1, rom_idx2;
    logic [W_WIDTH-1:0]   rom_w1, rom_w2;
    assign rom_w2   = bus.rom_data[W_WIDTH-1:0];
    assign rom_idx2 = bus.rom_data[W_WIDTH+IDX_WIDTH-1:W_WIDTH];
    assign rom_w1   = bus.rom_data[2*W_WIDTH+IDX_WIDTH-1:W_WIDTH+IDX_WIDTH];
    assign rom_idx1 = bus.rom_data[2*W_WIDTH+2*IDX_WIDTH-1:2*W_WIDTH+IDX_WIDTH];

    assign accept = bus.s_valid & s_ready_q;
    assign out_hs = m_valid_q & bus.m_ready;

    assign bus.s_ready  = s_ready_q;
    assign bus.rom_addr = bin_cnt_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_idx    = m_idx_q;
    assign bus.m_last   = m_last_q;

    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        out_cnt_d   = out_cnt_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    bin_cnt_d = bin_cnt_q + 1'b1;
                    if (bin_cnt_q == LastBin) begin
                        state_d     = StDrain;
                        drain_cnt_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                // Two cycles let the last sample pass S1 and land in S2.
                if (drain_cnt_q) begin
                    state_d     = StOutput;
                    drain_cnt_d = 1'b0;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            StOutput: begin
                if (out_hs) begin
                    if (m_last_q) begin
                        state_d   = StAccum;
                        out_cnt_d = '0;
                        bin_cnt_d = '0;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // Products keep the integer part of p0 * Q0.16 weight.
    always_comb begin
        prod1_d = ACC_WIDTH'((ProdWidth'(p0_q) * ProdWidth'(rom_w1)) >> W_WIDTH);
        prod2_d = ACC_WIDTH'((ProdWidth'(p0_q) * ProdWidth'(rom_w2)) >> W_WIDTH);
    end

    // Out-of-range indices match no band and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_MEL; i++) begin
            acc_d[i] = acc_q[i];
            if (v1_q && idx1_q == IDX_WIDTH'(i)) acc_d[i] = acc_d[i] + prod1_q;
            if (v1_q && idx2_q == IDX_WIDTH'(i)) acc_d[i] = acc_d[i] + prod2_q;
            if (out_hs && out_cnt_q == IDX_WIDTH'(i)) acc_d[i] = '0;
        end
    end

    always_comb begin
        m_sel = '0;
        for (int i = 0; i < NUM_MEL; i++) begin
            if (out_cnt_d == IDX_WIDTH'(i)) m_sel = acc_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccum;
            bin_cnt_q   <= '0;
            out_cnt_q   <= '0;
            drain_cnt_q <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            out_cnt_q   <= out_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            s_ready_q   <= (state_d == StAccum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q    <= '0;
            v0_q    <= 1'b0;
            idx1_q  <= '0;
            idx2_q  <= '0;
            prod1_q <= '0;
            prod2_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            v0_q <= accept;
            v1_q <= v0_q;
            if (accept) p0_q <= bus.s_data;
            if (v0_q) begin
                idx1_q  <= rom_idx1;
                idx2_q  <= rom_idx2;
                prod1_q <= prod1_d;
                prod2_q <= prod2_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MEL; i++) acc_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MEL; i++) acc_q[i] <= acc_d[i];
        end
    end

    // Output registers load from next-state values so the first band is fresh on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= (state_d == StOutput);
            m_data_q  <= (state_d == StOutput) ? m_sel : '0;
            m_idx_q   <= (state_d == StOutput) ? out_cnt_d : '0;
            m_last_q  <= (state_d == StOutput) && (out_cnt_d == LastBand);
        end
    end
endmodule

// File: tb/tb_mel_accumulator.sv
// Directed bench for mel_accumulator: a ROM model, a frame-level reference sum, and a per-cycle
// compare process on the band output stream.
module tb_mel_accumulator;
    localparam int NB   = 257;
    localparam int NM   = 40;
    localparam int CYCLE_LIMIT = 4000;

    logic clk;
    logic rst_n;

    mel_accumulator_if bus ();

    mel_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    always @(posedge clk) cycle++;

    logic [43:0] rom_mem [512];
    logic [31:0] samp [NB];
    logic [39:0] exp_acc [NM];
    logic [39:0] got [NM];
    int exp_next = 0;
    int bands_seen = 0;
    int first_mv = -1;
    int last_acc = -1;
    bit prev_mv = 1'b0;

    // Coefficient ROM with one cycle of registered read latency.
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out after %0d cycles, expected progress", name, CYCLE_LIMIT);
        finish_run();
    endtask

    // Reference: band energy is the wrapped sum of floor(power * weight / 2^16) over all bins.
    task automatic build_expected();
        logic [43:0] word;
        logic [63:0] p;
        for (int i = 0; i < NM; i++) exp_acc[i] = '0;
        for (int b = 0; b < NB; b++) begin
            word = rom_mem[b];
            if (word[43:38] < NM) begin
                p = (64'(samp[b]) * 64'(word[37:22])) >> 16;
                exp_acc[word[43:38]] = exp_acc[word[43:38]] + p[39:0];
            end
            if (word[21:16] < NM) begin
                p = (64'(samp[b]) * 64'(word[15:0])) >> 16;
                exp_acc[word[21:16]] = exp_acc[word[21:16]] + p[39:0];
            end
        end
    endtask

    task automatic load_basic_rom();
        for (int b = 0; b < 512; b++) rom_mem[b] = '0;
        for (int b = 0; b < NB; b++) rom_mem[b] = {6'(b % NM), 16'h8000, 6'd63, 16'h0000};
    endtask

    task automatic load_samples(input logic [31:0] v);
        for (int b = 0; b < NB; b++) samp[b] = v;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_next = 0;
            prev_mv = 1'b0;
        end else begin
            if (bus.m_valid) begin
                if (!prev_mv) first_mv = cycle;
                check("m_idx", 64'(bus.m_idx), 64'(exp_next));
                check("m_data", 64'(bus.m_data), 64'(exp_acc[exp_next]));
                check("m_last", 64'(bus.m_last), 64'(exp_next == NM - 1));
                check("s_ready_in_output", 64'(bus.s_ready), 64'd0);
                if (bus.m_ready) begin
                    got[bus.m_idx] = bus.m_data;
                    bands_seen++;
                    exp_next = (exp_next == NM - 1) ? 0 : exp_next + 1;
                end
            end
            prev_mv = bus.m_valid;
        end
    end

    // Called just after a rising edge; returns just after the edge that takes the last bin.
    task automatic send_bins(input int count, input bit bubbly);
        bit ok;
        int guard;
        for (int b = 0; b < count; b++) begin
            if (bubbly) begin
                while ($urandom_range(1, 0) == 0) begin
                    bus.s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = samp[b];
            guard = 0;
            ok = 1'b0;
            while (!ok) begin
                @(negedge clk);
                ok = bus.s_ready;
                if (ok && b == NB - 1) last_acc = cycle;
                @(posedge clk);
                #1;
                guard++;
                if (guard > CYCLE_LIMIT) timeout("s_ready_wait");
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic hold_at_band3();
        logic [39:0] held;
        int guard = 0;
        while (!(bus.m_valid && bus.m_idx == 6'd3)) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > CYCLE_LIMIT) timeout("band3_wait");
        end
        bus.m_ready = 1'b0;
        held = bus.m_data;
        check("bp_held_value", 64'(held), 64'(exp_acc[3]));
        repeat (10) begin
            @(negedge clk);
            check("bp_m_valid", 64'(bus.m_valid), 64'd1);
            check("bp_m_idx", 64'(bus.m_idx), 64'd3);
            check("bp_m_data", 64'(bus.m_data), 64'(held));
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
    endtask

    task automatic run_frame(input bit bubbly, input bit backpress);
        int guard = 0;
        bands_seen = 0;
        first_mv = -1;
        last_acc = -1;
        build_expected();
        send_bins(NB, bubbly);
        repeat (2) begin
            @(negedge clk);
            check("drain_s_ready", 64'(bus.s_ready), 64'd0);
            check("drain_m_valid", 64'(bus.m_valid), 64'd0);
        end
        if (backpress) hold_at_band3();
        while (bands_seen < NM) begin
            @(negedge clk);
            guard++;
            if (guard > CYCLE_LIMIT) timeout("frame_output");
        end
        @(negedge clk);
        check("post_frame_m_valid", 64'(bus.m_valid), 64'd0);
        check("post_frame_s_ready", 64'(bus.s_ready), 64'd1);
        check("bands_per_frame", 64'(bands_seen), 64'(NM));
        check("first_m_valid_latency", 64'(first_mv - last_acc), 64'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        load_basic_rom();
        load_samples(32'd1000);
        build_expected();

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_data", 64'(bus.m_data), 64'd0);
        check("rst_m_idx", 64'(bus.m_idx), 64'd0);
        check("rst_m_last", 64'(bus.m_last), 64'd0);
        check("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("accum_s_ready", 64'(bus.s_ready), 64'd1);

        // Basic frame.
        run_frame(1'b0, 1'b0);
        check("t1_band0", 64'(got[0]), 64'd3500);
        check("t1_band16", 64'(got[16]), 64'd3500);
        check("t1_band17", 64'(got[17]), 64'd3000);
        check("t1_band39", 64'(got[39]), 64'd3000);

        // Both pairs of bin 0 hit band 5.
        for (int b = 0; b < NB; b++) rom_mem[b] = {6'(b % NM), 16'h0000, 6'd0, 16'h0000};
        rom_mem[0] = {6'd5, 16'hFFFF, 6'd5, 16'h0001};
        load_samples(32'h0001_0000);
        run_frame(1'b0, 1'b0);
        check("t2_band5", 64'(got[5]), 64'h1_0000);
        check("t2_band4", 64'(got[4]), 64'd0);
        check("t2_band6", 64'(got[6]), 64'd0);

        // Backpressure at band 3.
        load_basic_rom();
        load_samples(32'd1000);
        run_frame(1'b0, 1'b1);
        check("t3_band3", 64'(got[3]), 64'd3500);
        check("t3_band20", 64'(got[20]), 64'd3000);

        // Bubbly input.
        run_frame(1'b1, 1'b0);
        check("t4_band10", 64'(got[10]), 64'd3500);
        check("t4_band30", 64'(got[30]), 64'd3000);

        // Zero frame right behind: accumulators must have been cleared.
        load_samples(32'd0);
        run_frame(1'b0, 1'b0);
        check("t5_band0", 64'(got[0]), 64'd0);
        check("t5_band39", 64'(got[39]), 64'd0);

        // Reset after bin 100, then a clean frame.
        load_samples(32'd1000);
        send_bins(101, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_rom_addr", 64'(bus.rom_addr), 64'd0);
        check("midrst_s_ready", 64'(bus.s_ready), 64'd0);
        check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1'b0, 1'b0);
        check("t6_band0", 64'(got[0]), 64'd3500);
        check("t6_band16", 64'(got[16]), 64'd3500);
        check("t6_band17", 64'(got[17]), 64'd3000);

        finish_run();
    end
endmodule
